mem_stream_reader: RTL and testbench
====================================

Name: mem_stream_reader

Overview:
- Downstream consumer of the paired even/odd tuple memory.
- On `start`, walks the memory from row 0 and issues one read per row pair.
- Latches the even/odd `tuple_pair_t` words that return one cycle later.
- Emits them as an in-order valid/ready stream, index 0 first, to the range-processing stage.

Parameters:
- ADDR_WIDTH, default `BANK_ADDR_WIDTH: row address width of the memory.
- MAX_TUPLES, default `BANK_DEPTH: capacity check bound for tuple_count.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begin a scan. Ignored unless idle.
- tuple_count  input  ADDR_WIDTH+1  number of valid tuples; sampled on an accepted start
- mem_read_en  output  1  read strobe to memory
- mem_row_addr  output  ADDR_WIDTH  row address; LSB always 0
- even_data_in  input  $bits(tuple_pair_t)  memory even-bank read data
- odd_data_in  input  $bits(tuple_pair_t)  memory odd-bank read data
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts
- out_data  output  $bits(tuple_pair_t)  current tuple
- out_last  output  1  qualifies the final tuple of the scan
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Clock and reset:
  - Single clock `clock`; `reset` is synchronous and active-high.
  - Reset values:
    - mem_read_en=0, mem_row_addr=0
    - out_valid=0, out_data=0, out_last=0
    - busy=0, done=0
    - state=IDLE, all counters 0
- Memory contract:
  - Read data is valid exactly one cycle after mem_read_en=1.
  - Data is not guaranteed held afterwards, so both words are latched in that cycle.
  - A row at address 2k holds tuple 2k (even) and tuple 2k+1 (odd).
- States:
  - IDLE:
    - On start, latch tuple_count into cnt_r and clear idx (tuple index, ADDR_WIDTH+1 bits).
    - If tuple_count==0, go to FIN.
    - Otherwise go to REQ. busy=1 from the cycle after start.
  - REQ:
    - mem_read_en=1 and mem_row_addr={idx[ADDR_WIDTH-1:1],1'b0} for exactly one cycle.
    - Go to CAP.
  - CAP:
    - Latch even_data_in into even_r and odd_data_in into odd_r.
    - Go to EMIT_E.
  - EMIT_E:
    - out_valid=1, out_data=even_r, out_last=(idx+1==cnt_r).
    - On out_valid&&out_ready: idx++.
    - If last, go to FIN; otherwise go to EMIT_O.
  - EMIT_O:
    - out_valid=1, out_data=odd_r, out_last=(idx+1==cnt_r).
    - On handshake: idx++.
    - If last, go to FIN; otherwise go to REQ.
  - FIN:
    - done=1 for one cycle, busy=0.
    - Go to IDLE.
- Stream rules:
  - out_data and out_last stay stable while out_valid&&!out_ready.
  - out_valid never drops without a handshake.
  - out_valid is 0 in all states other than EMIT_E and EMIT_O.
- Odd tuple_count: the odd word of the final row is fetched but never emitted. Last is asserted in EMIT_E.
- Throughput: 2 tuples per 4 cycles minimum. No prefetch.
- Out-of-range count: a tuple_count above MAX_TUPLES is clamped to MAX_TUPLES, and an assertion fires in simulation.
- start while busy: ignored, no effect on the current scan.
- Simultaneous start and reset: reset wins.
- Reset mid-scan:
  - Immediate return to IDLE with all outputs at reset values.
  - No done pulse.
  - A read issued in the previous cycle is discarded.

Decomposition:
- In the aoc5 package/header:
  - tuple_pair_t, already shared.
  - New reader_state_t enum: IDLE, REQ, CAP, EMIT_E, EMIT_O, FIN.
- Address and count widths are derived from `BANK_ADDR_WIDTH and `BANK_DEPTH in aoc5.svh.
- No sub-module. The block is a single FSM with a datapath of two holding registers and an index counter.

Test Plan:
- Full-row scan:
  - Stimulus: memory preloaded with tuples 0..3 = {(1,5),(2,6),(3,7),(4,8)}, tuple_count=4, out_ready=1.
  - Required: out_data order (1,5),(2,6),(3,7),(4,8); out_last only on (4,8); reads at rows 0 and 2 only; done pulses once.
- Odd count:
  - Stimulus: same memory, tuple_count=3.
  - Required: three tuples emitted, out_last on (3,7), (4,8) never on out_data, done pulses once.
- Zero count:
  - Stimulus: tuple_count=0 with start.
  - Required: no mem_read_en, no out_valid, done pulses 2 cycles after start.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles while out_valid=1 on tuple 1.
  - Required: out_data held at (2,6), no extra reads, sequence unchanged once ready returns.
- Start while busy:
  - Stimulus: start with tuple_count=4, then start with tuple_count=1 mid-scan.
  - Required: second start ignored, 4 tuples emitted.
- Reset mid-scan:
  - Stimulus: reset in EMIT_O of row 0.
  - Required: next cycle all outputs 0, busy=0, no done pulse; a fresh start with tuple_count=2 emits (1,5),(2,6) correctly.

Source files
------------

// File: rtl/mem_stream_reader_pkg.sv
// Shared types for the paired even/odd tuple memory and its stream reader.
package mem_stream_reader_pkg;

    localparam int unsigned BankAddrWidth = 4;
    localparam int unsigned BankDepth     = 16;
    localparam int unsigned TupleFieldW   = 16;

    typedef struct packed {
        logic [TupleFieldW-1:0] lo;
        logic [TupleFieldW-1:0] hi;
    } tuple_pair_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCap,
        StEmitE,
        StEmitO,
        StFin
    } reader_state_t;

endpackage

// File: rtl/mem_stream_reader.sv
// Scans the paired even/odd tuple memory row by row and replays the tuples
// as an in-order valid/ready stream, index 0 first.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BankAddrWidth,
    parameter int unsigned MAX_TUPLES = BankDepth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   tuple_count,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_row_addr,
    input  tuple_pair_t           even_data_in,
    input  tuple_pair_t           odd_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output tuple_pair_t           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned     CntW     = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] MaxCount = CntW'(MAX_TUPLES);

    reader_state_t   state_q;
    logic [CntW-1:0] idx_q;
    logic [CntW-1:0] cnt_q;
    tuple_pair_t     odd_q;

    logic [CntW-1:0] idx_inc;
    logic [CntW-1:0] idx_inc2;
    logic [CntW-1:0] count_clamped;

    always_comb begin
        idx_inc       = idx_q + CntW'(1);
        idx_inc2      = idx_q + CntW'(2);
        count_clamped = (tuple_count > MaxCount) ? MaxCount : tuple_count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            odd_q        <= '0;
            mem_read_en  <= 1'b0;
            mem_row_addr <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mem_read_en <= 1'b0;
            done        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q <= count_clamped;
                        idx_q <= '0;
                        if (count_clamped == '0) begin
                            state_q <= StFin;
                        end else begin
                            state_q      <= StReq;
                            busy         <= 1'b1;
                            mem_read_en  <= 1'b1;
                            mem_row_addr <= '0;
                        end
                    end
                end
                StReq: begin
                    state_q <= StCap;
                end
                StCap: begin
                    // out_data doubles as the even holding register; the memory
                    // does not hold read data past this cycle.
                    odd_q     <= odd_data_in;
                    out_data  <= even_data_in;
                    out_valid <= 1'b1;
                    out_last  <= (idx_inc == cnt_q);
                    state_q   <= StEmitE;
                end
                StEmitE: begin
                    if (out_ready) begin
                        idx_q <= idx_inc;
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state_q   <= StFin;
                        end else begin
                            out_data <= odd_q;
                            out_last <= (idx_inc2 == cnt_q);
                            state_q  <= StEmitO;
                        end
                    end
                end
                StEmitO: begin
                    if (out_ready) begin
                        idx_q     <= idx_inc;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            busy    <= 1'b0;
                            state_q <= StFin;
                        end else begin
                            mem_read_en  <= 1'b1;
                            mem_row_addr <= {idx_inc[ADDR_WIDTH-1:1], 1'b0};
                            state_q      <= StReq;
                        end
                    end
                end
                StFin: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Oversized counts are clamped in hardware but flagged in simulation.
    count_in_range: assert property (@(posedge clock) disable iff (reset)
        !(state_q == StIdle && start && tuple_count > MaxCount))
        else $error("tuple_count above MAX_TUPLES");

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a one-cycle-latency memory model.
module tb_mem_stream_reader;
    import mem_stream_reader_pkg::*;

    localparam int AW = BankAddrWidth;
    localparam int CW = AW + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] tuple_count;
    logic          mem_read_en;
    logic [AW-1:0] mem_row_addr;
    logic [31:0]   even_data_in;
    logic [31:0]   odd_data_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:31];
    logic [31:0] exp_t [0:3];

    logic [31:0]   obs_data [$];
    logic          obs_last [$];
    logic [AW-1:0] rd_addr [$];
    int            done_cnt;
    int            valid_cyc;

    mem_stream_reader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .tuple_count  (tuple_count),
        .mem_read_en  (mem_read_en),
        .mem_row_addr (mem_row_addr),
        .even_data_in (even_data_in),
        .odd_data_in  (odd_data_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Memory model: data valid only in the cycle after the strobe, garbage otherwise.
    always @(posedge clock) begin
        if (mem_read_en) begin
            even_data_in <= mem[int'(mem_row_addr)];
            odd_data_in  <= mem[int'(mem_row_addr) + 1];
        end else begin
            even_data_in <= 32'hdead_beef;
            odd_data_in  <= 32'hbad0_bad0;
        end
    end

    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
        end
        if (mem_read_en) rd_addr.push_back(mem_row_addr);
        if (done) done_cnt++;
        if (out_valid) valid_cyc++;
    end

    task automatic clear_logs();
        obs_data.delete();
        obs_last.delete();
        rd_addr.delete();
        done_cnt  = 0;
        valid_cyc = 0;
    endtask

    task automatic start_scan(input logic [CW-1:0] n);
        @(posedge clock);
        #1 start = 1'b1;
        tuple_count = n;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s_done_timeout: got no done, required done within 200 cycles", name);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tuple_count = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({mem_read_en, out_valid, out_last, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {mem_read_en, out_valid, out_last, busy, done});
        end
        vectors++;
        if (mem_row_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h, required 0", mem_row_addr);
        end
        vectors++;
        if (out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, required 0", out_data);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_full_row();
        clear_logs();
        start_scan(CW'(4));
        wait_done("full_row");
        vectors++;
        if (obs_data.size() !== 4) begin
            miscompares++;
            $display("FAIL full_row_count: got %0d tuples, required 4", obs_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < obs_data.size()) begin
                vectors++;
                if (obs_data[i] !== exp_t[i] || obs_last[i] !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL full_row_tuple%0d: got %h last %b, required %h last %b",
                             i, obs_data[i], obs_last[i], exp_t[i], (i == 3));
                end
            end
        end
        vectors++;
        if (rd_addr.size() !== 2 || rd_addr[0] !== AW'(0) || rd_addr[1] !== AW'(2)) begin
            miscompares++;
            $display("FAIL full_row_reads: got %0d reads, required 2 reads at rows 0,2",
                     rd_addr.size());
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL full_row_done: got %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_odd_count();
        clear_logs();
        start_scan(CW'(3));
        wait_done("odd_count");
        vectors++;
        if (obs_data.size() !== 3) begin
            miscompares++;
            $display("FAIL odd_count_count: got %0d tuples, required 3", obs_data.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < obs_data.size()) begin
                vectors++;
                if (obs_data[i] !== exp_t[i] || obs_last[i] !== (i == 2)) begin
                    miscompares++;
                    $display("FAIL odd_count_tuple%0d: got %h last %b, required %h last %b",
                             i, obs_data[i], obs_last[i], exp_t[i], (i == 2));
                end
            end
        end
        vectors++;
        if (rd_addr.size() !== 2) begin
            miscompares++;
            $display("FAIL odd_count_reads: got %0d reads, required 2", rd_addr.size());
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL odd_count_done: got %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        logic [2:0] seen;
        clear_logs();
        start_scan(CW'(0));
        @(negedge clock) seen[2] = done;
        @(negedge clock) seen[1] = done;
        @(negedge clock) seen[0] = done;
        vectors++;
        if (seen !== 3'b010) begin
            miscompares++;
            $display("FAIL zero_done_timing: got %b, required 010", seen);
        end
        vectors++;
        if (rd_addr.size() !== 0 || valid_cyc !== 0) begin
            miscompares++;
            $display("FAIL zero_activity: got %0d reads %0d valid cycles, required 0 and 0",
                     rd_addr.size(), valid_cyc);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        start_scan(CW'(4));
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if ({out_valid, out_data, out_last} !== {1'b1, exp_t[1], 1'b0}) begin
                miscompares++;
                $display("FAIL backpressure_hold%0d: got v%b %h l%b, required v1 %h l0",
                         i, out_valid, out_data, out_last, exp_t[1]);
            end
        end
        vectors++;
        if (rd_addr.size() !== 1) begin
            miscompares++;
            $display("FAIL backpressure_reads: got %0d reads, required 1", rd_addr.size());
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        wait_done("backpressure");
        vectors++;
        if (obs_data.size() !== 4) begin
            miscompares++;
            $display("FAIL backpressure_count: got %0d tuples, required 4", obs_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < obs_data.size()) begin
                vectors++;
                if (obs_data[i] !== exp_t[i] || obs_last[i] !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL backpressure_tuple%0d: got %h last %b, required %h last %b",
                             i, obs_data[i], obs_last[i], exp_t[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        clear_logs();
        start_scan(CW'(4));
        repeat (2) @(posedge clock);
        #1 start = 1'b1;
        tuple_count = CW'(1);
        @(posedge clock);
        #1 start = 1'b0;
        wait_done("busy_start");
        vectors++;
        if (obs_data.size() !== 4) begin
            miscompares++;
            $display("FAIL busy_start_count: got %0d tuples, required 4", obs_data.size());
        end
        if (obs_data.size() == 4) begin
            vectors++;
            if (obs_data[3] !== exp_t[3] || obs_last[3] !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_start_last: got %h last %b, required %h last 1",
                         obs_data[3], obs_last[3], exp_t[3]);
            end
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL busy_start_done: got %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_logs();
        start_scan(CW'(4));
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({mem_read_en, out_valid, out_last, busy, done, mem_row_addr, out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got en%b v%b l%b b%b d%b a%h %h, required all 0",
                     mem_read_en, out_valid, out_last, busy, done, mem_row_addr, out_data);
        end
        repeat (6) @(negedge clock);
        vectors++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d done pulses busy %b, required 0 and 0",
                     done_cnt, busy);
        end
        clear_logs();
        start_scan(CW'(2));
        wait_done("reset_mid_rescan");
        vectors++;
        if (obs_data.size() !== 2) begin
            miscompares++;
            $display("FAIL reset_mid_count: got %0d tuples, required 2", obs_data.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < obs_data.size()) begin
                vectors++;
                if (obs_data[i] !== exp_t[i] || obs_last[i] !== (i == 1)) begin
                    miscompares++;
                    $display("FAIL reset_mid_tuple%0d: got %h last %b, required %h last %b",
                             i, obs_data[i], obs_last[i], exp_t[i], (i == 1));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {16'(100 + i), 16'(200 + i)};
        exp_t[0] = {16'd1, 16'd5};
        exp_t[1] = {16'd2, 16'd6};
        exp_t[2] = {16'd3, 16'd7};
        exp_t[3] = {16'd4, 16'd8};
        for (int i = 0; i < 4; i++) mem[i] = exp_t[i];
        clear_logs();

        test_reset();
        test_full_row();
        test_odd_count();
        test_zero_count();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_scan();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
        $fatal(1);
    end

endmodule
